// File: rtl/life_gen_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : life_gen_sequencer
// Brief   : Double-banked 8x8 toroidal Life board; walks rows through an
//           external row decoder per step and swaps banks at commit.
//           Optional still-life detection: LIFE_STABLE_DETECT_EN.
// Revision: 1.0  initial release
// ============================================================================
module life_gen_sequencer #(
  parameter int ROWS  = 8,
  parameter int GEN_W = 8
) (
  input  logic             ph1,
  input  logic             reset_n,
  input  logic             step_req,
  output logic             busy,
  output logic             gen_done,
  input  logic             load_we,
  input  logic [2:0]       load_addr,
  input  logic [7:0]       load_data,
  output logic [7:0]       row_in,
  output logic [7:0]       row_a,
  output logic [7:0]       row_b,
  input  logic [7:0]       row_out,
  input  logic [2:0]       disp_addr,
  output logic [7:0]       disp_row,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_bank0 [ROWS];
  logic [7:0]       r_bank1 [ROWS];
  logic             r_cur_sel;
  logic [2:0]       r_row;
  logic [GEN_W-1:0] r_gen_count;
  logic             r_gen_done;
  logic [7:0]       r_disp_row;
  logic [2:0]       w_row_up;
  logic [2:0]       w_row_dn;
  logic [7:0]       w_cur_mid;
  logic [7:0]       w_cur_up;
  logic [7:0]       w_cur_dn;
  logic [7:0]       w_cur_disp;

  // 3-bit arithmetic gives the vertical torus wrap for free
  assign w_row_up = r_row - 3'd1;
  assign w_row_dn = r_row + 3'd1;

  always_comb begin
    w_cur_mid  = r_cur_sel ? r_bank1[r_row]     : r_bank0[r_row];
    w_cur_up   = r_cur_sel ? r_bank1[w_row_up]  : r_bank0[w_row_up];
    w_cur_dn   = r_cur_sel ? r_bank1[w_row_dn]  : r_bank0[w_row_dn];
    w_cur_disp = r_cur_sel ? r_bank1[disp_addr] : r_bank0[disp_addr];
  end

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    row_in       = '0;
    row_a        = '0;
    row_b        = '0;
    case (r_state)
      S_IDLE: begin
        if (step_req) w_state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        row_in = w_cur_mid;
        row_a  = w_cur_up;
        row_b  = w_cur_dn;
        if (r_row == 3'd7) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

`ifdef LIFE_STABLE_DETECT_EN
  logic r_diff;
  logic r_stable;
`endif

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
      r_cur_sel   <= 1'b0;
      r_row       <= '0;
      r_gen_count <= '0;
      r_gen_done  <= 1'b0;
      r_disp_row  <= '0;
`ifdef LIFE_STABLE_DETECT_EN
      r_diff      <= 1'b0;
      r_stable    <= 1'b0;
`endif
    end else begin
      r_gen_done <= 1'b0;
      r_disp_row <= w_cur_disp;
      case (r_state)
        S_IDLE: begin
          // the write lands before a same-cycle step, so the step sees it
          if (load_we) begin
            if (r_cur_sel) r_bank1[load_addr] <= load_data;
            else           r_bank0[load_addr] <= load_data;
`ifdef LIFE_STABLE_DETECT_EN
            r_stable <= 1'b0;
`endif
          end
          if (step_req) begin
            r_row <= '0;
`ifdef LIFE_STABLE_DETECT_EN
            r_diff <= 1'b0;
`endif
          end
        end
        S_COMPUTE: begin
          if (r_cur_sel) r_bank0[r_row] <= row_out;
          else           r_bank1[r_row] <= row_out;
          r_row <= r_row + 3'd1;
`ifdef LIFE_STABLE_DETECT_EN
          r_diff <= r_diff | (row_out != w_cur_mid);
`endif
        end
        S_COMMIT: begin
          r_cur_sel  <= ~r_cur_sel;
          r_gen_done <= 1'b1;
`ifdef LIFE_STABLE_DETECT_EN
          r_stable <= ~r_diff;
          if (r_diff) r_gen_count <= r_gen_count + GEN_W'(1);
`else
          r_gen_count <= r_gen_count + GEN_W'(1);
`endif
        end
        default: begin
          r_row <= '0;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen_count;
  assign disp_row  = r_disp_row;
`ifdef LIFE_STABLE_DETECT_EN
  assign stable    = r_stable;
`else
  assign stable    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_gen_sequencer.sv
`default_nettype none
// Bench for life_gen_sequencer: acts as the row decoder and compares every
// cycle against a whole-board Life model, plus hand-computed board checks.
module tb_life_gen_sequencer;

  logic       ph1 = 1'b0;
  logic       reset_n;
  logic       step_req;
  logic       busy;
  logic       gen_done;
  logic       load_we;
  logic [2:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] row_in;
  logic [7:0] row_a;
  logic [7:0] row_b;
  logic [7:0] row_out;
  logic [2:0] disp_addr;
  logic [7:0] disp_row;
  logic [7:0] gen_count;
  logic       stable;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  life_gen_sequencer #(.ROWS(8), .GEN_W(8)) dut (
    .ph1(ph1), .reset_n(reset_n), .step_req(step_req), .busy(busy),
    .gen_done(gen_done), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .row_in(row_in), .row_a(row_a), .row_b(row_b),
    .row_out(row_out), .disp_addr(disp_addr), .disp_row(disp_row),
    .gen_count(gen_count), .stable(stable)
  );

  always #5 ph1 = ~ph1;

  // Life rule for a single cell given its live-neighbour count
  function automatic logic rule(input logic alive, input int cnt);
    return (cnt == 3) || (alive && cnt == 2);
  endfunction

  // external row decoder: three rows in, next state of the middle row out
  function automatic logic [7:0] dec_row(input logic [7:0] a, input logic [7:0] m,
                                         input logic [7:0] b);
    logic [7:0] n;
    n = '0;
    for (int x = 0; x < 8; x++) begin
      int cnt;
      cnt = a[(x+7)&7] + a[x] + a[(x+1)&7] + m[(x+7)&7] + m[(x+1)&7]
          + b[(x+7)&7] + b[x] + b[(x+1)&7];
      n[x] = rule(m[x], cnt);
    end
    return n;
  endfunction

  always_comb row_out = dec_row(row_a, row_in, row_b);

  // whole-board generation on a torus; cell (y,x) is bit y*8+x
  function automatic logic [63:0] life_step(input logic [63:0] bd);
    logic [63:0] n;
    n = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int cnt;
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) cnt += bd[((y+dy)&7)*8 + ((x+dx)&7)];
        n[y*8+x] = rule(bd[y*8+x], cnt);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] with_load(input logic [63:0] bd, input logic [2:0] a,
                                            input logic [7:0] d);
    logic [63:0] n;
    n = bd;
    n[a*8 +: 8] = d;
    return n;
  endfunction

  // model: m_phase counts cycles since the accepted request (0 = idle)
  logic [63:0] m_board, m_pend;
  int          m_phase;
  logic [7:0]  m_gen, m_disp;
  logic        m_done, m_stable;

  always @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      m_board <= '0; m_pend <= '0; m_phase <= 0; m_gen <= '0;
      m_disp <= '0; m_done <= 1'b0; m_stable <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_disp <= m_board[disp_addr*8 +: 8];
      if (m_phase == 0) begin
        if (load_we) begin
          m_board  <= with_load(m_board, load_addr, load_data);
          m_stable <= 1'b0;
        end
        if (step_req) begin
          m_phase <= 1;
          m_pend  <= life_step(load_we ? with_load(m_board, load_addr, load_data) : m_board);
        end
      end else if (m_phase < 9) begin
        m_phase <= m_phase + 1;
      end else begin
        m_board <= m_pend;
        m_phase <= 0;
        m_done  <= 1'b1;
`ifdef LIFE_STABLE_DETECT_EN
        m_stable <= (m_pend == m_board);
        if (m_pend != m_board) m_gen <= m_gen + 8'd1;
`else
        m_gen <= m_gen + 8'd1;
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ph1) begin
    if (chk_en) begin
      logic [7:0] e_in, e_a, e_b;
      int r;
      e_in = '0; e_a = '0; e_b = '0;
      if (m_phase >= 1 && m_phase <= 8) begin
        r    = m_phase - 1;
        e_in = m_board[r*8 +: 8];
        e_a  = m_board[((r+7)&7)*8 +: 8];
        e_b  = m_board[((r+1)&7)*8 +: 8];
      end
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_phase != 0});
      chk("cyc_gen_done", {31'd0, gen_done}, {31'd0, m_done});
      chk("cyc_gen_count", {24'd0, gen_count}, {24'd0, m_gen});
      chk("cyc_stable", {31'd0, stable}, {31'd0, m_stable});
      chk("cyc_disp_row", {24'd0, disp_row}, {24'd0, m_disp});
      chk("cyc_row_in", {24'd0, row_in}, {24'd0, e_in});
      chk("cyc_row_a", {24'd0, row_a}, {24'd0, e_a});
      chk("cyc_row_b", {24'd0, row_b}, {24'd0, e_b});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ph1);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic load_row(input logic [2:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    cyc(1);
    load_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    disp_addr = a;
    cyc(1);
    chk(name, {24'd0, disp_row}, {24'd0, exp});
  endtask

  // one generation; optional wrap probes and a dropped load during COMPUTE
  task automatic step(input bit probe_wrap, input bit inject);
    int lat, nb;
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    if (probe_wrap) chk("wrap_r0_row_a", {24'd0, row_a}, 32'h04);
    nb  = busy ? 1 : 0;
    lat = 21;
    for (int k = 1; k <= 20; k++) begin
      if (inject && k == 2) begin
        load_we = 1'b1; load_addr = 3'd5; load_data = 8'hFF;
      end
      if (inject && k == 3) load_we = 1'b0;
      cyc(1);
      if (gen_done) begin
        lat = k;
        break;
      end
      if (busy) nb++;
      if (probe_wrap && k == 7) chk("wrap_r7_row_b", {24'd0, row_b}, 32'h04);
    end
    chk("step_latency", lat, 9);
    chk("step_busy_cycles", nb, 9);
  endtask

  initial begin
    int last, pulses, n;
    reset_n = 1'b1; step_req = 1'b0; load_we = 1'b0;
    load_addr = '0; load_data = '0; disp_addr = '0;
    #2;
    reset_n = 1'b0;
    chk_en  = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_gen_count", {24'd0, gen_count}, 32'd0);
    chk("reset_stable", {31'd0, stable}, 32'd0);

    // blinker, two generations
    load_row(3'd3, 8'b00011100);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      rd(i[2:0], (i >= 2 && i <= 4) ? 8'b00001000 : 8'h00, "blinker_gen1_row");
    chk("blinker_gen_count", {24'd0, gen_count}, 32'd1);
    step(1'b0, 1'b0);
    rd(3'd3, 8'b00011100, "blinker_gen2_row3");
    rd(3'd2, 8'h00, "blinker_gen2_row2");
    rd(3'd4, 8'h00, "blinker_gen2_row4");

    // vertical blinker across the row 7 / row 0 seam
    do_reset();
    load_row(3'd7, 8'b00000100);
    load_row(3'd0, 8'b00000100);
    load_row(3'd1, 8'b00000100);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      rd(i[2:0], (i == 0) ? 8'b00001110 : 8'h00, "wrap_row");

    // load attempted during COMPUTE is dropped
    do_reset();
    load_row(3'd3, 8'b00011100);
    step(1'b0, 1'b1);
    rd(3'd5, 8'h00, "busy_load_row5");
    rd(3'd3, 8'b00001000, "busy_load_row3");

    // reset while r=4
    do_reset();
    load_row(3'd3, 8'b00011100);
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(4);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_disp", {24'd0, disp_row}, 32'd0);
    for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "midreset_row");
    reset_n = 1'b1;
    cyc(1);
    chk("postreset_gen_count", {24'd0, gen_count}, 32'd0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "empty_step_row");

    // block still life
    do_reset();
    load_row(3'd3, 8'b00011000);
    load_row(3'd4, 8'b00011000);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rd(3'd3, 8'b00011000, "still_row3");
    rd(3'd4, 8'b00011000, "still_row4");
    rd(3'd5, 8'h00, "still_row5");
`ifdef LIFE_STABLE_DETECT_EN
    chk("still_stable", {31'd0, stable}, 32'd1);
    chk("still_gen_count", {24'd0, gen_count}, 32'd0);
`else
    chk("still_stable", {31'd0, stable}, 32'd0);
    chk("still_gen_count", {24'd0, gen_count}, 32'd2);
`endif

    // 256 back-to-back generations wrap the counter
    do_reset();
    load_row(3'd3, 8'b00011100);
    step_req = 1'b1;
    pulses = 0;
    last   = 0;
    n      = 0;
    while (pulses < 256 && n < 3000) begin
      cyc(1);
      n++;
      if (gen_done) begin
        if (pulses > 0) chk("wrap_done_spacing", n - last, 10);
        last = n;
        pulses++;
      end
    end
    step_req = 1'b0;
    chk("wrap_pulses", pulses, 256);
    chk("wrap_gen_count", {24'd0, gen_count}, 32'd0);
    cyc(2);
    rd(3'd3, 8'b00011100, "wrap_board_row3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation sequencer for the 8x8 toroidal Life board. It holds the board in two row banks and, on each step request, walks rows 0–7 through the external row decoder (`decoder_top`), presenting the current row and its two vertical neighbours and capturing the returned next-state row. It then swaps banks. It sits directly upstream of the row decoder and feeds the display controller through a registered row-read port.

## Interface
Parameters:
- `ROWS`, 8: board height; fixed at 8, because the row address is 3 bits wide.
- `GEN_W`, 8: width of the generation counter.

Ports:
- `ph1`, in, 1: the single clock, rising-edge active. One clock; reset is asynchronous and active-low.
- `reset_n`, in, 1: asynchronous active-low reset.
- `step_req`, in, 1: request one generation; level-sampled only while idle.
- `busy`, out, 1: high whenever the state is not IDLE.
- `gen_done`, out, 1: one-cycle pulse when the new generation is committed.
- `load_we`, in, 1: write strobe for the current bank.
- `load_addr`, in, 3: row index for the write.
- `load_data`, in, 8: row value for the write.
- `row_in`, out, 8: current row, to the decoder.
- `row_a`, out, 8: row above, index `(r-1) mod 8`, to the decoder.
- `row_b`, out, 8: row below, index `(r+1) mod 8`, to the decoder.
- `row_out`, in, 8: next-state row returned by the decoder; combinational from `row_in`/`row_a`/`row_b`.
- `disp_addr`, in, 3: display read row.
- `disp_row`, out, 8: registered contents of current-bank row `disp_addr`.
- `gen_count`, out, `GEN_W`: committed generation count.
- `stable`, out, 1: still-life flag (see Configuration).

## Operation
- There are two 8x8 banks, `bank0` and `bank1`. A `cur_sel` bit marks which bank is current; the other bank is next.
- States are IDLE, COMPUTE and COMMIT.
  - IDLE to COMPUTE: on `step_req=1`. The row counter `r` is set to 0.
  - COMPUTE: each cycle, `row_out` is written into `next[r]` and `r` increments. After `r=7` is captured, the state goes to COMMIT.
  - COMMIT: toggle `cur_sel`, increment `gen_count` (unless suppressed, see Configuration), assert `gen_done` for one cycle, then return to IDLE.
- Decoder outputs:
  - In COMPUTE: `row_in=cur[r]`, `row_a=cur[(r-1)&7]`, `row_b=cur[(r+1)&7]`. Row 0 takes row 7 as its upper neighbour; row 7 takes row 0 as its lower neighbour. Column wrap is handled by the decoder.
  - Outside COMPUTE: `row_in`, `row_a` and `row_b` are driven to 0.
- Load port:
  - A write is accepted only in IDLE and goes to `cur[load_addr]`.
  - `load_we` is ignored in COMPUTE and COMMIT; there is no queuing.
  - If `load_we` and `step_req` are both high in the same IDLE cycle, the write lands first. The computed generation includes it.
- `gen_count` wraps from `2^GEN_W-1` to 0 with no flag.
- `step_req` held high across consecutive generations restarts COMPUTE in the cycle after COMMIT returns to IDLE. There is therefore one IDLE cycle between generations.

## Timing
- Let E0 be the edge at which IDLE samples `step_req=1`.
- Edges E1–E8 capture rows 0–7.
- E9 commits. `gen_done` and the new `gen_count` are visible between E9 and E10.
- Total latency from request to done is 9 cycles.
- `disp_row` has 1-cycle latency from `disp_addr`. It reads the current bank; reads after E9 see the new generation.
- Reset (asynchronous, any state including mid-COMPUTE) forces:
  - both banks to 0;
  - `cur_sel=0`, state IDLE, `r=0`;
  - `busy=0`, `gen_done=0`, `gen_count=0`, `stable=0`, `disp_row=0`;
  - `row_in`, `row_a`, `row_b` to 0.
- A partially written next bank is discarded by reset.

## Configuration
- `LIFE_STABLE_DETECT_EN` defined:
  - During COMPUTE, a sticky `diff` bit ORs `row_out != cur[r]`. It is cleared on entry to COMPUTE.
  - At COMMIT, `stable` is set to `~diff`.
  - When `~diff`, `gen_count` is not incremented. `gen_done` still pulses and the bank swap still occurs.
  - `stable` clears on reset or when any `load_we` is accepted.
- Macro undefined: `stable` is tied to 0, `gen_count` always increments, and no diff logic is present.

## Test plan
- Blinker: load row 3 = `8'b00011100`, others 0, then pulse `step_req`.
  - `gen_done` fires 9 cycles after acceptance.
  - Rows 2, 3 and 4 read `8'b00001000`; all other rows are 0.
  - `gen_count=1`.
  - A second step restores the original board.
- Vertical wrap: load rows 7, 0 and 1 = `8'b00000100` (vertical blinker spanning the wrap), then step.
  - Row 0 reads `8'b00001110`; all other rows are 0.
  - During COMPUTE, `r=0` shows `row_a=cur[7]` and `r=7` shows `row_b=cur[0]`.
- Load while busy: assert `load_we` with addr 5 and data `8'hFF` during COMPUTE.
  - Row 5 after commit equals the computed value only; the write is dropped.
  - `busy=1` for the 9 cycles from E1 through E9.
- Reset mid-operation: drop `reset_n` at the cycle where `r=4`.
  - Immediately: `busy=0` and all `disp_row` reads return 0.
  - After release: `gen_count=0`, and the next step on the empty board yields all zeros.
- Still life with `LIFE_STABLE_DETECT_EN`: load rows 3 and 4 = `8'b00011000`, then step twice.
  - The board is unchanged, `stable=1` and `gen_count` stays 0.
  - Without the macro, `stable=0` and `gen_count=2`.
- Counter wrap: hold `step_req` high for 256 generations on the blinker with the macro undefined.
  - `gen_count` returns to 0.
  - `gen_done` pulses are exactly 10 cycles apart.
